// File: rtl/synth_pkg.sv
// Shared types and constants for the synth voice datapath.
// Holds the envelope state encoding and the common sample width.
package synth_pkg;

  localparam int SAMPLE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    ATTACK,
    DECAY,
    SUSTAIN,
    RELEASE
  } env_state_t;

endpackage

// File: rtl/env_tick.sv
// Envelope prescaler: counts 0..TICK_DIV-1 and flags the last count as tick.
// A synchronous clear restarts the count so every envelope stage begins on a full period.
module env_tick #(
  parameter int TICK_DIV = 150
) (
  input  logic clk,
  input  logic nRst,
  input  logic clear,
  output logic tick
);

  localparam logic [9:0] LAST = 10'(TICK_DIV - 1);

  logic [9:0] count;

  assign tick = (count == LAST);

  always_ff @(posedge clk or posedge nRst) begin
    if (nRst) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 10'd1;
    end
  end

endmodule

// File: rtl/adsr_envelope.sv
// ADSR envelope generator with a registered sample scaler.
// The gate drives stage changes immediately; level only moves on prescaler ticks.
module adsr_envelope
  import synth_pkg::*;
#(
  parameter int TICK_DIV = 150,
  parameter int ATK_STEP = 4,
  parameter int DEC_STEP = 2,
  parameter int REL_STEP = 1
) (
  input  logic                clk,
  input  logic                nRst,
  input  logic                gate,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic [SAMPLE_W-1:0] sustain_lvl,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic [SAMPLE_W-1:0] env_level,
  output logic                busy
);

  localparam logic [8:0] ATK9 = 9'(ATK_STEP);
  localparam logic [8:0] DEC9 = 9'(DEC_STEP);
  localparam logic [8:0] REL9 = 9'(REL_STEP);

  env_state_t     state, state_next;
  logic [7:0]     level, level_next;
  logic           busy_r;
  logic           tick;
  logic           clear;
  logic [8:0]     sum9;
  logic [8:0]     gap9;
  logic [15:0]    product;

  env_tick #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .nRst (nRst),
    .clear(clear),
    .tick (tick)
  );

  // Each stage starts its own tick period, so the prescaler restarts on any state change.
  assign clear   = (state == IDLE) || (state_next != state);
  assign sum9    = {1'b0, level} + ATK9;
  assign gap9    = {1'b0, level} - {1'b0, sustain_lvl};
  assign product = 16'(sample_in) * 16'(level);

  // Gate checks come first in every stage so they win over a coincident tick.
  always_comb begin
    state_next = state;
    level_next = level;
    case (state)
      IDLE: begin
        if (gate) state_next = ATTACK;
      end
      ATTACK: begin
        if (!gate) begin
          state_next = RELEASE;
        end else if (tick) begin
          if (sum9 >= 9'd255) begin
            level_next = 8'hFF;
            state_next = DECAY;
          end else begin
            level_next = sum9[7:0];
          end
        end
      end
      DECAY: begin
        if (!gate) begin
          state_next = RELEASE;
        end else if (level <= sustain_lvl) begin
          state_next = SUSTAIN;
        end else if (tick) begin
          if (gap9 <= DEC9) begin
            level_next = sustain_lvl;
            state_next = SUSTAIN;
          end else begin
            level_next = 8'({1'b0, level} - DEC9);
          end
        end
      end
      SUSTAIN: begin
        if (!gate) state_next = RELEASE;
      end
      RELEASE: begin
        if (gate) begin
          state_next = ATTACK;
        end else if (tick) begin
          if ({1'b0, level} <= REL9) begin
            level_next = 8'd0;
            state_next = IDLE;
          end else begin
            level_next = 8'({1'b0, level} - REL9);
          end
        end
      end
      default: begin
        state_next = IDLE;
        level_next = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge nRst) begin
    if (nRst) begin
      state      <= IDLE;
      level      <= 8'd0;
      busy_r     <= 1'b0;
      sample_out <= '0;
    end else begin
      state      <= state_next;
      level      <= level_next;
      busy_r     <= (state_next != IDLE);
      sample_out <= product[15:8];
    end
  end

  assign env_level = level;
  assign busy      = busy_r;

endmodule

// File: tb/tb_adsr_envelope.sv
// Directed bench for adsr_envelope with short ticks and coarse steps.
// Expected levels are hand-derived from the envelope rules for TICK_DIV=4.
module tb_adsr_envelope;

  logic       clk;
  logic       nRst;
  logic       gate;
  logic [7:0] sample_in;
  logic [7:0] sustain_lvl;
  logic [7:0] sample_out;
  logic [7:0] env_level;
  logic       busy;

  int compared;
  int mismatched;

  adsr_envelope #(
    .TICK_DIV(4),
    .ATK_STEP(64),
    .DEC_STEP(32),
    .REL_STEP(64)
  ) dut (
    .clk        (clk),
    .nRst       (nRst),
    .gate       (gate),
    .sample_in  (sample_in),
    .sustain_lvl(sustain_lvl),
    .sample_out (sample_out),
    .env_level  (env_level),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic applyStimulus(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  initial begin
    compared    = 0;
    mismatched  = 0;
    nRst        = 1'b1;
    gate        = 1'b0;
    sample_in   = 8'd0;
    sustain_lvl = 8'd128;

    applyStimulus(2);
    checkOutput("reset_level", int'(env_level), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_sample", int'(sample_out), 0);

    nRst = 1'b0;
    gate = 1'b1;
    applyStimulus(1);
    checkOutput("attack_entry_level", int'(env_level), 0);
    checkOutput("attack_entry_busy", int'(busy), 1);
    applyStimulus(4);
    checkOutput("attack_64", int'(env_level), 64);
    applyStimulus(4);
    checkOutput("attack_128", int'(env_level), 128);
    applyStimulus(4);
    checkOutput("attack_192", int'(env_level), 192);
    applyStimulus(4);
    checkOutput("attack_255", int'(env_level), 255);
    applyStimulus(4);
    checkOutput("decay_223", int'(env_level), 223);
    applyStimulus(4);
    checkOutput("decay_191", int'(env_level), 191);
    applyStimulus(4);
    checkOutput("decay_159", int'(env_level), 159);
    applyStimulus(4);
    checkOutput("decay_floor_128", int'(env_level), 128);
    applyStimulus(8);
    checkOutput("sustain_hold", int'(env_level), 128);
    checkOutput("sustain_busy", int'(busy), 1);

    sample_in = 8'd200;
    applyStimulus(1);
    checkOutput("scale_200x128", int'(sample_out), 100);

    gate = 1'b0;
    applyStimulus(1);
    checkOutput("release_entry", int'(env_level), 128);
    applyStimulus(4);
    checkOutput("release_64", int'(env_level), 64);
    applyStimulus(4);
    checkOutput("release_0", int'(env_level), 0);
    checkOutput("idle_busy", int'(busy), 0);

    gate = 1'b1;
    applyStimulus(9);
    checkOutput("second_attack_128", int'(env_level), 128);
    gate = 1'b0;
    applyStimulus(5);
    checkOutput("release_to_64", int'(env_level), 64);
    gate = 1'b1;
    applyStimulus(1);
    checkOutput("retrigger_entry", int'(env_level), 64);
    applyStimulus(4);
    checkOutput("retrigger_128", int'(env_level), 128);
    applyStimulus(4);
    checkOutput("retrigger_192", int'(env_level), 192);
    sustain_lvl = 8'd255;
    applyStimulus(4);
    checkOutput("retrigger_255", int'(env_level), 255);
    applyStimulus(9);
    checkOutput("sustain_at_255", int'(env_level), 255);
    sample_in = 8'd255;
    applyStimulus(1);
    checkOutput("scale_255x255", int'(sample_out), 254);

    gate = 1'b0;
    applyStimulus(20);
    checkOutput("full_release_level", int'(env_level), 0);
    checkOutput("full_release_busy", int'(busy), 0);

    sustain_lvl = 8'd128;
    gate = 1'b1;
    applyStimulus(9);
    checkOutput("pre_reset_level", int'(env_level), 128);
    applyStimulus(1);
    checkOutput("pre_reset_sample", int'(sample_out), 127);
    nRst = 1'b1;
    #1;
    checkOutput("async_reset_level", int'(env_level), 0);
    checkOutput("async_reset_sample", int'(sample_out), 0);
    checkOutput("async_reset_busy", int'(busy), 0);
    #1;
    nRst = 1'b0;
    applyStimulus(1);
    checkOutput("restart_entry", int'(env_level), 0);
    checkOutput("restart_busy", int'(busy), 1);
    applyStimulus(4);
    checkOutput("restart_64", int'(env_level), 64);

    applyStimulus(3);
    gate = 1'b0;
    applyStimulus(1);
    checkOutput("gate_beats_tick_level", int'(env_level), 64);
    checkOutput("gate_beats_tick_busy", int'(busy), 1);
    applyStimulus(4);
    checkOutput("late_release_0", int'(env_level), 0);
    checkOutput("late_release_busy", int'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
